// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central sequencer.
// The master side is the datapath (ID/EX/MEM); the slave side is pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int unsigned StallW = 6,
  parameter int unsigned CntW   = 6,
  parameter int unsigned PerfW  = 32
);
  logic              stallreq_id;
  logic              ex_mc_req;
  logic [CntW-1:0]   ex_mc_len;
  logic              flush_req;
  logic [StallW-1:0] stall;
  logic              flush;
  logic              ex_mc_busy;
  logic              ex_mc_done;
  logic [PerfW-1:0]  stall_cycles;

  modport master (
    output stallreq_id, ex_mc_req, ex_mc_len, flush_req,
    input  stall, flush, ex_mc_busy, ex_mc_done, stall_cycles
  );

  modport slave (
    input  stallreq_id, ex_mc_req, ex_mc_len, flush_req,
    output stall, flush, ex_mc_busy, ex_mc_done, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: per-stage stall vector, flush, multi-cycle EX sequencing
// and a saturating stall-cycle performance counter.
module pipe_ctrl #(
  parameter int unsigned StallW = 6,
  parameter int unsigned CntW   = 6,
  parameter int unsigned PerfW  = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  pipe_ctrl_if.slave  bus
);

  localparam logic [StallW-1:0] StallNone = '0;
  localparam logic [StallW-1:0] StallId   = StallW'(6'b000111);
  localparam logic [StallW-1:0] StallEx   = StallW'(6'b001111);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PerfW-1:0]  perf_q, perf_d;
  logic [StallW-1:0] stall;
  logic              flush;
  logic              done;
  logic [StallW-1:0] stall_id;

  assign stall_id = bus.stallreq_id ? StallId : StallNone;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = StallNone;
    flush   = 1'b0;
    done    = 1'b0;
    if (bus.flush_req) begin
      // Flush aborts any multi-cycle op, including one being offered this cycle.
      flush   = 1'b1;
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.ex_mc_req && (bus.ex_mc_len != '0)) begin
            stall   = StallEx;
            cnt_d   = bus.ex_mc_len - CntW'(1);
            state_d = (bus.ex_mc_len == CntW'(1)) ? StDone : StRun;
          end else begin
            stall = stall_id;
          end
        end
        StRun: begin
          stall = StallEx;
          if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
          // <= 1 rather than == 1 so a corrupted zero count cannot lock the pipe.
          if (cnt_q <= CntW'(1)) state_d = StDone;
        end
        StDone: begin
          done    = 1'b1;
          stall   = stall_id;
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    perf_d = perf_q;
    if ((stall != StallNone) && (perf_q != '1)) perf_d = perf_q + PerfW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  // Outputs are forced quiet while reset is held, even though ID hazards may be live.
  assign bus.stall        = rst_ni ? stall : StallNone;
  assign bus.flush        = rst_ni & flush;
  assign bus.ex_mc_done   = rst_ni & done;
  assign bus.ex_mc_busy   = rst_ni & (state_q == StRun);
  assign bus.stall_cycles = perf_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a per-cycle vector table plus hand-written sequences
// for asynchronous reset, ID hazard counting and the maximum-length op.
module tb_pipe_ctrl;

  localparam logic [5:0] SNone = 6'b000000;
  localparam logic [5:0] SId   = 6'b000111;
  localparam logic [5:0] SEx   = 6'b001111;

  typedef struct {
    string      name;
    logic       id;
    logic       req;
    logic [5:0] len;
    logic       fl;
    logic [5:0] stall;
    logic       flush;
    logic       busy;
    logic       done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   perf_model = 0;
  vec_t vecs[$];

  pipe_ctrl_if bus ();

  pipe_ctrl u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic id, input logic req, input logic [5:0] len, input logic fl);
    bus.stallreq_id = id;
    bus.ex_mc_req   = req;
    bus.ex_mc_len   = len;
    bus.flush_req   = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic id, input logic req, input logic [5:0] len,
                     input logic fl, input logic [5:0] st, input logic efl, input logic eb,
                     input logic ed);
    vec_t v;
    v.name = n; v.id = id; v.req = req; v.len = len; v.fl = fl;
    v.stall = st; v.flush = efl; v.busy = eb; v.done = ed;
    vecs.push_back(v);
  endtask

  initial begin
    int nstall;
    bit seen_done;

    //     name        id  req len  fl  stall  fl  busy done
    add("l5_acc",    0, 1, 6'd5, 0, SEx,   0, 0, 0);
    add("l5_run1",   0, 1, 6'd5, 0, SEx,   0, 1, 0);
    add("l5_run2",   0, 1, 6'd5, 0, SEx,   0, 1, 0);
    add("l5_run3",   0, 1, 6'd5, 0, SEx,   0, 1, 0);
    add("l5_run4",   0, 1, 6'd5, 0, SEx,   0, 1, 0);
    add("l5_done",   0, 1, 6'd5, 0, SNone, 0, 0, 1);
    add("l5_idle",   0, 0, 6'd0, 0, SNone, 0, 0, 0);
    add("l1_acc",    0, 1, 6'd1, 0, SEx,   0, 0, 0);
    add("l1_done",   0, 1, 6'd1, 0, SNone, 0, 0, 1);
    add("l1_idle",   0, 0, 6'd0, 0, SNone, 0, 0, 0);
    add("l0_req",    0, 1, 6'd0, 0, SNone, 0, 0, 0);
    add("l0_req_id", 1, 1, 6'd0, 0, SId,   0, 0, 0);
    add("l0_idle",   0, 0, 6'd0, 0, SNone, 0, 0, 0);
    add("l8_acc",    0, 1, 6'd8, 0, SEx,   0, 0, 0);
    add("l8_run1",   0, 1, 6'd8, 0, SEx,   0, 1, 0);
    add("l8_flush",  0, 1, 6'd8, 1, SNone, 1, 1, 0);
    add("l8_after",  0, 0, 6'd0, 0, SNone, 0, 0, 0);
    add("l8_nodone", 0, 0, 6'd0, 0, SNone, 0, 0, 0);
    add("acc_flush", 1, 1, 6'd3, 1, SNone, 1, 0, 0);
    add("accf_idle", 0, 0, 6'd0, 0, SNone, 0, 0, 0);
    add("dn_acc",    0, 1, 6'd1, 0, SEx,   0, 0, 0);
    add("dn_flush",  0, 1, 6'd1, 1, SNone, 1, 0, 0);
    add("dn_idle",   0, 0, 6'd0, 0, SNone, 0, 0, 0);
    add("l4id_acc",  1, 1, 6'd4, 0, SEx,   0, 0, 0);
    add("l4id_run1", 1, 1, 6'd4, 0, SEx,   0, 1, 0);
    add("l4id_run2", 1, 1, 6'd4, 0, SEx,   0, 1, 0);
    add("l4id_run3", 1, 1, 6'd4, 0, SEx,   0, 1, 0);
    add("l4id_done", 1, 1, 6'd4, 0, SId,   0, 0, 1);
    add("l4id_idle", 0, 0, 6'd0, 0, SNone, 0, 0, 0);

    // Reset holds outputs quiet even with live requests.
    drive(1, 0, 6'd0, 1);
    #2;
    check("rst_stall", 32'(bus.stall), 32'(SNone));
    check("rst_flush", 32'(bus.flush), 0);
    check("rst_busy",  32'(bus.ex_mc_busy), 0);
    check("rst_done",  32'(bus.ex_mc_done), 0);
    check("rst_perf",  bus.stall_cycles, 0);
    drive(0, 0, 6'd0, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    next_cycle();

    // Async reset in the middle of a len=10 op, on its 4th stall cycle.
    drive(0, 1, 6'd10, 0);
    #1 check("r10_acc", 32'(bus.stall), 32'(SEx));
    next_cycle(); next_cycle(); next_cycle();
    #1 check("r10_busy", 32'(bus.ex_mc_busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("r10_rst_stall", 32'(bus.stall), 32'(SNone));
    check("r10_rst_busy",  32'(bus.ex_mc_busy), 0);
    check("r10_rst_perf",  bus.stall_cycles, 0);
    drive(0, 0, 6'd0, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("r10_post_stall", 32'(bus.stall), 32'(SNone));
      check("r10_post_busy",  32'(bus.ex_mc_busy), 0);
      check("r10_post_done",  32'(bus.ex_mc_done), 0);
      next_cycle();
    end
    check("r10_post_perf", bus.stall_cycles, 0);

    // ID hazard for exactly three cycles.
    drive(1, 0, 6'd0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("id3_stall", 32'(bus.stall), 32'(SId));
      next_cycle();
    end
    drive(0, 0, 6'd0, 0);
    @(negedge clk);
    check("id3_release", 32'(bus.stall), 32'(SNone));
    check("id3_perf", bus.stall_cycles, 3);
    next_cycle();
    perf_model = 3;

    foreach (vecs[i]) begin
      drive(vecs[i].id, vecs[i].req, vecs[i].len, vecs[i].fl);
      @(negedge clk);
      check({vecs[i].name, "_stall"}, 32'(bus.stall), 32'(vecs[i].stall));
      check({vecs[i].name, "_flush"}, 32'(bus.flush), 32'(vecs[i].flush));
      check({vecs[i].name, "_busy"},  32'(bus.ex_mc_busy), 32'(vecs[i].busy));
      check({vecs[i].name, "_done"},  32'(bus.ex_mc_done), 32'(vecs[i].done));
      check({vecs[i].name, "_perf"},  bus.stall_cycles, 32'(perf_model));
      if (vecs[i].stall != SNone) perf_model++;
      next_cycle();
    end

    // Maximum length: 63 stall cycles, then the done pulse.
    drive(0, 1, 6'd63, 0);
    nstall = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ex_mc_done) begin
        seen_done = 1'b1;
        check("l63_done_stall", 32'(bus.stall), 32'(SNone));
        break;
      end
      if (bus.stall == SEx) nstall++;
      next_cycle();
    end
    check("l63_seen_done", 32'(seen_done), 1);
    check("l63_stalls", 32'(nstall), 63);
    drive(0, 0, 6'd0, 0);
    next_cycle();
    @(negedge clk);
    check("l63_perf", bus.stall_cycles, 32'(perf_model + 63));
    check("l63_idle_done", 32'(bus.ex_mc_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
